// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: holds the PC, issues one word-aligned fetch at a
// time, captures the returned word and hands {pc, inst} to decode.
//
// state  | meaning
// S_REQ  | request presented at pc, waiting for memory to accept it
// S_WAIT | request accepted, waiting for the single response
// S_HOLD | instruction presented to decode, waiting for out_ready
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic        req_valid_q;
  logic [31:0] redirect_tgt;
  logic        req_accept;

  // Redirect target is forced to a word boundary; a request only issues while presented.
  assign redirect_tgt   = redirect_pc & ~32'h3;
  assign req_accept     = req_valid_q & imem_req_ready;
  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;

  // Fetch sequencer; redirect has priority in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid   <= 1'b0;
      out_pc      <= 32'h0;
      out_inst    <= 32'h0;
      fetch_cnt   <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_accept) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
            if (redirect_valid) begin
              // The accepted request is already out; its response must be dropped.
              kill <= 1'b1;
              pc   <= redirect_tgt;
            end
          end else begin
            req_valid_q <= 1'b1;
            if (redirect_valid) pc <= redirect_tgt;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (redirect_valid || kill) begin
              kill        <= 1'b0;
              state       <= S_REQ;
              req_valid_q <= 1'b1;
              if (redirect_valid) pc <= redirect_tgt;
            end else begin
              out_inst  <= imem_resp_data;
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc + PC_STEP;
              state     <= S_HOLD;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
            pc   <= redirect_tgt;
          end
        end
        S_HOLD: begin
          if (redirect_valid || out_ready) begin
            out_valid   <= 1'b0;
            state       <= S_REQ;
            req_valid_q <= 1'b1;
            if (out_ready) fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect_valid) pc <= redirect_tgt;
          end
        end
        default: begin
          state       <= S_REQ;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ifu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .fetch_cnt       (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts with a request presented and req_ready=1; runs one fetch through
  // WAIT and HOLD, stalling decode for 'stall' cycles, then delivers it.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data,
                           input int stall, input logic [31:0] exp_cnt);
    chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, exp_addr);
    step();
    chk("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("wait_out_valid", {31'b0, out_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    out_ready       = (stall == 0);
    step();
    imem_resp_valid = 1'b0;
    chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
    chk("hold_out_pc", out_pc, exp_addr);
    chk("hold_out_inst", out_inst, data);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_out_pc", out_pc, exp_addr);
      chk("stall_out_inst", out_inst, data);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("stall_cnt", fetch_cnt, exp_cnt - 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("done_out_valid", {31'b0, out_valid}, 32'd0);
    chk("done_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("done_cnt", fetch_cnt, exp_cnt);
  endtask

  initial begin
    rst_n           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    out_ready       = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_addr", imem_addr, 32'h8000_0000);

    // Release; memory back-pressures the first request for 4 cycles.
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("bp_addr", imem_addr, 32'h8000_0000);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd0);
      step();
    end
    imem_req_ready = 1'b1;

    // Back-to-back fetches, then one with decode stalled for 5 cycles.
    fetch_one(32'h8000_0000, 32'h0000_0013, 0, 32'd1);
    fetch_one(32'h8000_0004, 32'h0010_0093, 0, 32'd2);
    fetch_one(32'h8000_0008, 32'h0020_0113, 0, 32'd3);
    fetch_one(32'h8000_000C, 32'h1234_5678, 5, 32'd4);

    // Redirect in WAIT kills the in-flight response.
    chk("r1_addr", imem_addr, 32'h8000_0010);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("r1_out_valid", {31'b0, out_valid}, 32'd0);
    chk("r1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("r1_cnt", fetch_cnt, 32'd4);
    fetch_one(32'h8000_0100, 32'hCAFE_0001, 0, 32'd5);

    // Redirect in REQ while not accepted, to the top word; then PC wraps.
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("r2_addr", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    fetch_one(32'hFFFF_FFFC, 32'hABCD_0000, 0, 32'd6);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Redirect in HOLD without out_ready drops the instruction.
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h5555_AAAA;
    out_ready       = 1'b0;
    step();
    imem_resp_valid = 1'b0;
    chk("r3_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("r3_hold_pc", out_pc, 32'h0000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("r3_out_valid", {31'b0, out_valid}, 32'd0);
    chk("r3_addr", imem_addr, 32'h8000_0200);
    chk("r3_cnt", fetch_cnt, 32'd6);

    // Reset during WAIT; the late response must be ignored.
    step();
    chk("rw_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rw_rst_cnt", fetch_cnt, 32'd0);
    step();
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    step();
    imem_resp_valid = 1'b0;
    chk("rw_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rw_req_valid2", {31'b0, imem_req_valid}, 32'd1);
    chk("rw_addr", imem_addr, 32'h8000_0000);
    chk("rw_cnt", fetch_cnt, 32'd0);
    step();
    chk("rw_wait_out_valid", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch initiator for the NPC core; drives the instruction-memory responder.
- Holds the PC and issues one aligned 32-bit fetch at a time over a valid/ready request channel.
- Captures the returned word and presents {pc, inst} to decode over a valid/ready output channel.
- Handles control-flow redirects, including squashing an in-flight response; counts delivered instructions.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  load redirect_pc as next fetch address.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  32  fetch address; always word-aligned.
- imem_resp_valid  in  1  response data valid (one per accepted request, ≥1 cycle later).
- imem_resp_data  in  32  fetched instruction word.
- out_valid  out  1  {out_pc, out_inst} valid to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  32  PC of presented instruction.
- out_inst  out  32  presented instruction.
- fetch_cnt  out  32  instructions delivered (out_valid & out_ready).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=REQ; kill=0.
  - imem_req_valid=0 while rst_n=0; out_valid=0; out_pc=0; out_inst=0; fetch_cnt=0.
  - First request asserts in the first cycle after rst_n deasserts.
- State REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready=1 → WAIT.
  - Address stays stable until accepted, except on redirect.
- State WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with kill=0: out_inst<=imem_resp_data, out_pc<=pc, out_valid<=1, pc<=pc+PC_STEP → HOLD.
  - On imem_resp_valid with kill=1: discard data, kill<=0 → REQ.
- State HOLD:
  - out_valid=1; outputs held stable.
  - On out_ready: out_valid<=0, fetch_cnt+=1 → REQ.
  - Minimum period is 3 cycles per instruction with single-cycle memory.
- Redirect (highest priority, sampled each cycle):
  - REQ without req_ready: pc<=redirect_pc & ~3, stay REQ; the new address is presented next cycle.
  - REQ with req_ready in the same cycle: the request is considered issued; kill<=1, pc<=redirect target → WAIT.
  - WAIT, no response this cycle: kill<=1, pc<=redirect target.
  - WAIT, response this cycle: response discarded, pc<=redirect target → REQ.
  - HOLD, no out_ready: out_valid<=0, instruction dropped, pc<=redirect target → REQ.
  - HOLD with out_ready: the transfer counts (fetch_cnt+=1), pc<=redirect target → REQ.
- Arithmetic:
  - pc+PC_STEP wraps modulo 2^32 (32'hFFFF_FFFC → 0).
  - fetch_cnt wraps modulo 2^32.
- Protocol rules:
  - At most one outstanding request.
  - imem_resp_valid outside WAIT is ignored.
  - Reset mid-transaction discards everything; the in-flight response after reset is ignored, because state REQ ignores responses.

Test Plan:
- Reset release, memory always ready, 1-cycle response, out_ready=1 → requests at 8000_0000, 8000_0004, 8000_0008; out_pc matches each address; fetch_cnt=3 after three handshakes.
- Hold imem_req_ready=0 for 4 cycles → imem_addr stays 8000_0000 with imem_req_valid=1; request accepted on cycle 5; no out_valid before the response.
- Hold out_ready=0 for 5 cycles in HOLD → out_valid, out_pc and out_inst stable; no new imem request; fetch_cnt unchanged until out_ready=1.
- In WAIT, pulse redirect_valid with redirect_pc=8000_0102, then return response 0xDEADBEEF → response dropped (no out_valid); next request addr=8000_0100; fetch_cnt unchanged.
- pc at FFFF_FFFC, deliver one instruction → next imem_addr=0000_0000.
- Assert rst_n=0 during WAIT, then return a response after release → out_valid stays 0; first request at RESET_PC; fetch_cnt=0.
